// File: rtl/exec_mc.sv
// Execute unit: single-cycle ALU plus a restoring divider that retires one
// quotient bit per clock, with a sticky halt state left only through reset.
module exec_mc #(
    parameter int WORD  = 32,
    parameter int W_RD  = 5,
    parameter int W_OPC = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             v_i,
    output logic             ready_o,
    input  logic [W_OPC-1:0] opc_i,
    input  logic [WORD-1:0]  src_i,
    input  logic [WORD-1:0]  dest_i,
    input  logic             wb_i,
    input  logic [W_RD-1:0]  rd_num_i,
    output logic             wb_o,
    output logic [W_RD-1:0]  rd_num_o,
    output logic [WORD-1:0]  rd_data_o,
    output logic [3:0]       status_o,
    output logic             busy_o,
    output logic             halted_o
);
    localparam int CW = $clog2(WORD) + 1;

    localparam logic [W_OPC-1:0] OP_ADD  = 3'd0;
    localparam logic [W_OPC-1:0] OP_SUB  = 3'd1;
    localparam logic [W_OPC-1:0] OP_AND  = 3'd2;
    localparam logic [W_OPC-1:0] OP_OR   = 3'd3;
    localparam logic [W_OPC-1:0] OP_XOR  = 3'd4;
    localparam logic [W_OPC-1:0] OP_SLT  = 3'd5;
    localparam logic [W_OPC-1:0] OP_DIV  = 3'd6;
    localparam logic [W_OPC-1:0] OP_HALT = 3'd7;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_DIV = 2'd1, S_HALT = 2'd2} state_e;

    state_e            state_q, state_d;
    logic              wb_q, wb_d;
    logic [W_RD-1:0]   rd_num_q, rd_num_d;
    logic [WORD-1:0]   rd_data_q, rd_data_d;
    logic [3:0]        status_q, status_d;
    logic              busy_q, busy_d;
    logic              halted_q, halted_d;
    logic              div_wb_q, div_wb_d;
    logic [W_RD-1:0]   div_rd_q, div_rd_d;
    logic [WORD-1:0]   quo_q, quo_d;
    logic [WORD-1:0]   rem_q, rem_d;
    logic [WORD-1:0]   dvs_q, dvs_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic [WORD:0]     sum_s, diff_s, shift_s;
    logic [WORD-1:0]   alu_res_s, rem_next_s, quo_next_s;
    logic              alu_c_s, alu_v_s, ge_s;

    // {Z,C,N,V} from a result and the operation-specific carry/overflow bits
    function automatic logic [3:0] mk_flags(input logic [WORD-1:0] r, input logic c, input logic v);
        return {(r == {WORD{1'b0}}), c, r[WORD-1], v};
    endfunction

    assign ready_o   = ~busy_q & ~halted_q;
    assign wb_o      = wb_q;
    assign rd_num_o  = rd_num_q;
    assign rd_data_o = rd_data_q;
    assign status_o  = status_q;
    assign busy_o    = busy_q;
    assign halted_o  = halted_q;

    // Single-cycle ALU result and flags; DIV here covers only the divide-by-zero case
    always_comb begin
        sum_s     = {1'b0, dest_i} + {1'b0, src_i};
        diff_s    = {1'b0, dest_i} - {1'b0, src_i};
        alu_res_s = {WORD{1'b0}};
        alu_c_s   = 1'b0;
        alu_v_s   = 1'b0;
        case (opc_i)
            OP_ADD: begin
                alu_res_s = sum_s[WORD-1:0];
                alu_c_s   = sum_s[WORD];
                alu_v_s   = (dest_i[WORD-1] == src_i[WORD-1]) && (sum_s[WORD-1] != dest_i[WORD-1]);
            end
            OP_SUB: begin
                alu_res_s = diff_s[WORD-1:0];
                alu_c_s   = diff_s[WORD];
                alu_v_s   = (dest_i[WORD-1] != src_i[WORD-1]) && (diff_s[WORD-1] != dest_i[WORD-1]);
            end
            OP_AND:  alu_res_s = dest_i & src_i;
            OP_OR:   alu_res_s = dest_i | src_i;
            OP_XOR:  alu_res_s = dest_i ^ src_i;
            OP_SLT:  alu_res_s = {{(WORD-1){1'b0}}, ($signed(dest_i) < $signed(src_i))};
            OP_DIV: begin
                alu_res_s = {WORD{1'b1}};
                alu_v_s   = 1'b1;
            end
            default: alu_res_s = {WORD{1'b0}};
        endcase
    end

    // One restoring-division step: shift in the next dividend bit, subtract if it fits
    always_comb begin
        shift_s = {rem_q, quo_q[WORD-1]};
        ge_s    = (shift_s >= {1'b0, dvs_q});
        if (ge_s) begin
            rem_next_s = shift_s[WORD-1:0] - dvs_q;
        end else begin
            rem_next_s = shift_s[WORD-1:0];
        end
        quo_next_s = {quo_q[WORD-2:0], ge_s};
    end

    // Next-state and registered-output logic for IDLE / DIV / HALT
    always_comb begin
        state_d  = state_q;
        wb_d     = 1'b0;
        rd_num_d = rd_num_q;
        rd_data_d = rd_data_q;
        status_d = status_q;
        busy_d   = busy_q;
        halted_d = halted_q;
        div_wb_d = div_wb_q;
        div_rd_d = div_rd_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        dvs_d    = dvs_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (v_i && ready_o) begin
                    if (opc_i == OP_HALT) begin
                        state_d  = S_HALT;
                        halted_d = 1'b1;
                    end else if ((opc_i == OP_DIV) && (src_i != {WORD{1'b0}})) begin
                        state_d  = S_DIV;
                        busy_d   = 1'b1;
                        quo_d    = dest_i;
                        rem_d    = {WORD{1'b0}};
                        dvs_d    = src_i;
                        cnt_d    = {CW{1'b0}};
                        div_wb_d = wb_i;
                        div_rd_d = rd_num_i;
                    end else begin
                        wb_d      = wb_i;
                        rd_num_d  = rd_num_i;
                        rd_data_d = alu_res_s;
                        status_d  = mk_flags(alu_res_s, alu_c_s, alu_v_s);
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DIV: begin
                quo_d = quo_next_s;
                rem_d = rem_next_s;
                cnt_d = cnt_q + CW'(1);
                // Last quotient bit goes straight to the result so ready rises with wb_o
                if (cnt_q == CW'(WORD - 1)) begin
                    state_d   = S_IDLE;
                    busy_d    = 1'b0;
                    wb_d      = div_wb_q;
                    rd_num_d  = div_rd_q;
                    rd_data_d = quo_next_s;
                    status_d  = mk_flags(quo_next_s, 1'b0, 1'b0);
                end else begin
                    state_d = S_DIV;
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers, cleared asynchronously by rst
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            wb_q      <= 1'b0;
            rd_num_q  <= {W_RD{1'b0}};
            rd_data_q <= {WORD{1'b0}};
            status_q  <= 4'b0000;
            busy_q    <= 1'b0;
            halted_q  <= 1'b0;
            div_wb_q  <= 1'b0;
            div_rd_q  <= {W_RD{1'b0}};
            quo_q     <= {WORD{1'b0}};
            rem_q     <= {WORD{1'b0}};
            dvs_q     <= {WORD{1'b0}};
            cnt_q     <= {CW{1'b0}};
        end else begin
            state_q   <= state_d;
            wb_q      <= wb_d;
            rd_num_q  <= rd_num_d;
            rd_data_q <= rd_data_d;
            status_q  <= status_d;
            busy_q    <= busy_d;
            halted_q  <= halted_d;
            div_wb_q  <= div_wb_d;
            div_rd_q  <= div_rd_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dvs_q     <= dvs_d;
            cnt_q     <= cnt_d;
        end
    end
endmodule

// File: tb/tb_exec_mc.sv
// Randomized bench for exec_mc against a cycle-level reference model that
// computes results with plain arithmetic and counts divide latency in cycles.
module tb_exec_mc;
    logic        clk, rst, v_i, wb_i;
    logic [2:0]  opc_i;
    logic [31:0] src_i, dest_i;
    logic [4:0]  rd_num_i;
    logic        ready_o, wb_o, busy_o, halted_o;
    logic [4:0]  rd_num_o;
    logic [31:0] rd_data_o;
    logic [3:0]  status_o;

    int n_checks = 0;
    int n_errs   = 0;

    bit          m_halt;
    int          m_left;
    logic [31:0] m_q;
    logic        m_pwb;
    logic [4:0]  m_prd;
    logic        e_wb;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
    logic [3:0]  e_stat;

    exec_mc dut (
        .clk(clk), .rst(rst), .v_i(v_i), .ready_o(ready_o), .opc_i(opc_i),
        .src_i(src_i), .dest_i(dest_i), .wb_i(wb_i), .rd_num_i(rd_num_i),
        .wb_o(wb_o), .rd_num_o(rd_num_o), .rd_data_o(rd_data_o),
        .status_o(status_o), .busy_o(busy_o), .halted_o(halted_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void ref_op(input logic [2:0] op, input logic [31:0] d, input logic [31:0] s,
                                   output logic [31:0] r, output logic c, output logic v);
        longint unsigned ud = d;
        longint unsigned us = s;
        longint sd = $signed(d);
        longint ss = $signed(s);
        longint t;
        r = 32'd0; c = 1'b0; v = 1'b0;
        case (op)
            3'd0: begin r = d + s; c = (ud + us) > 64'hFFFF_FFFF; t = sd + ss;
                        v = (t > 64'sd2147483647) || (t < -64'sd2147483648); end
            3'd1: begin r = d - s; c = ud < us; t = sd - ss;
                        v = (t > 64'sd2147483647) || (t < -64'sd2147483648); end
            3'd2: r = d & s;
            3'd3: r = d | s;
            3'd4: r = d ^ s;
            3'd5: r = (sd < ss) ? 32'd1 : 32'd0;
            3'd6: if (s == 32'd0) begin r = 32'hFFFF_FFFF; v = 1'b1; end else r = d / s;
            default: r = 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_halt = 1'b0; m_left = 0; m_q = 32'd0; m_pwb = 1'b0; m_prd = 5'd0;
        e_wb = 1'b0; e_rd = 5'd0; e_data = 32'd0; e_stat = 4'd0;
    endtask

    // Advance the model by one rising edge using the currently driven inputs
    task automatic model_edge();
        bit rdy;
        logic [31:0] r;
        logic c, v;
        rdy = !m_halt && (m_left == 0);
        e_wb = 1'b0;
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                e_wb = m_pwb; e_rd = m_prd; e_data = m_q;
                e_stat = {m_q == 32'd0, 1'b0, m_q[31], 1'b0};
            end
        end else if (v_i && rdy) begin
            ref_op(opc_i, dest_i, src_i, r, c, v);
            if (opc_i == 3'd7) begin
                m_halt = 1'b1;
            end else if (opc_i == 3'd6 && src_i != 32'd0) begin
                m_left = 32; m_q = r; m_pwb = wb_i; m_prd = rd_num_i;
            end else begin
                e_wb = wb_i; e_rd = rd_num_i; e_data = r;
                e_stat = {r == 32'd0, c, r[31], v};
            end
        end
    endtask

    task automatic check_outs(input string t);
        check_eq({t, "_wb"},     wb_o,      e_wb);
        check_eq({t, "_rd"},     rd_num_o,  e_rd);
        check_eq({t, "_data"},   rd_data_o, e_data);
        check_eq({t, "_status"}, status_o,  e_stat);
        check_eq({t, "_busy"},   busy_o,    m_left > 0);
        check_eq({t, "_halted"}, halted_o,  m_halt);
        check_eq({t, "_ready"},  ready_o,   !m_halt && (m_left == 0));
    endtask

    task automatic step(input logic v, input logic [2:0] op, input logic [31:0] d,
                        input logic [31:0] s, input logic w, input logic [4:0] rd);
        v_i = v; opc_i = op; dest_i = d; src_i = s; wb_i = w; rd_num_i = rd;
        @(posedge clk);
        model_edge();
        #1;
        check_outs("cyc");
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        model_reset();
        check_outs("rst");
        repeat (2) @(posedge clk);
        #1;
        check_outs("rsthold");
        rst = 1'b1;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h7FFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int lowcnt;
        logic [2:0]  op;
        logic [31:0] d, s;
        v_i = 1'b0; opc_i = 3'd0; dest_i = 32'd0; src_i = 32'd0; wb_i = 1'b0; rd_num_i = 5'd0;
        do_reset();

        // Signed overflow on ADD
        step(1'b1, 3'd0, 32'h7FFF_FFFF, 32'd1, 1'b1, 5'd3);
        check_eq("add_data", rd_data_o, 64'h8000_0000);
        check_eq("add_flags", status_o, 64'h3);
        step(1'b1, 3'd1, 32'd5, 32'd5, 1'b1, 5'd4);
        check_eq("sub_flags", status_o, 64'h8);
        step(1'b1, 3'd5, 32'hFFFF_FFFF, 32'd1, 1'b0, 5'd6);
        check_eq("slt_data", rd_data_o, 64'h1);

        // Long divide with an ADD held on the inputs until accepted
        step(1'b1, 3'd6, 32'd100, 32'd7, 1'b1, 5'd9);
        lowcnt = 0;
        for (int i = 0; i < 40 && !ready_o; i++) begin
            lowcnt++;
            if (!wb_o) step(1'b1, 3'd0, 32'd1, 32'd2, 1'b1, 5'd10);
        end
        check_eq("div_ready_low", lowcnt, 32);
        check_eq("div_result", rd_data_o, 64'd14);
        step(1'b1, 3'd0, 32'd1, 32'd2, 1'b1, 5'd10);
        check_eq("add_after_div", rd_data_o, 64'd3);

        // Divide by zero completes in one cycle
        step(1'b1, 3'd6, 32'd55, 32'd0, 1'b1, 5'd11);
        check_eq("div0_data", rd_data_o, 64'hFFFF_FFFF);
        check_eq("div0_v", status_o[0], 64'h1);
        step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 5'd0);

        // Reset in the middle of a divide
        step(1'b1, 3'd6, 32'hDEAD_BEEF, 32'd3, 1'b1, 5'd12);
        repeat (10) step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 5'd0);
        do_reset();
        repeat (40) step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 5'd0);

        for (int i = 0; i < 3000; i++) begin
            op = 3'($urandom_range(0, 6));
            d = pick();
            s = pick();
            if (op == 3'd6 && $urandom_range(0, 3) == 0) s = 32'd0;
            step($urandom_range(0, 9) < 7, op, d, s, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
        end
        repeat (35) step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 5'd0);

        // HALT is sticky and blocks further work until reset
        step(1'b1, 3'd7, 32'd1, 32'd1, 1'b1, 5'd13);
        check_eq("halt_flag", halted_o, 64'h1);
        for (int i = 0; i < 6; i++) step(1'b1, 3'(i), pick(), pick(), 1'b1, 5'd14);
        do_reset();
        step(1'b1, 3'd4, 32'hF0F0_0000, 32'h0FF0_0001, 1'b1, 5'd15);
        check_eq("post_halt_xor", rd_data_o, 64'hFF00_0001);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end
endmodule

// File: doc/exec_mc.md
EXEC_MC -- requirements
Module: exec_mc

Interface
REQ-001 SHALL provide parameter WORD, default 32, operand/result width (>=4).
REQ-002 SHALL provide parameter W_RD, default 5, destination register number width.
REQ-003 SHALL provide parameter W_OPC, default 3, operation code width (fixed at 3; other values unsupported).
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 v_i  input  1  operation valid from decode.
REQ-007 ready_o  output  1  unit can accept an operation this cycle.
REQ-008 opc_i  input  W_OPC  operation: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 DIV, 7 HALT.
REQ-009 src_i, dest_i  input  WORD  operands.
REQ-010 wb_i  input  1  writeback requested.
REQ-011 rd_num_i  input  W_RD  destination register number.
REQ-012 wb_o  output  1  one-cycle writeback strobe to register file.
REQ-013 rd_num_o  output  W_RD  destination register for wb_o.
REQ-014 rd_data_o  output  WORD  result for wb_o.
REQ-015 status_o  output  4  flags {Z,C,N,V}.
REQ-016 busy_o  output  1  divide in progress.
REQ-017 halted_o  output  1  sticky halt indication.

Function
REQ-018 Acceptance SHALL occur on a rising edge where v_i=1 and ready_o=1; v_i while ready_o=0 SHALL be ignored (decode holds).
REQ-019 ready_o SHALL equal ~busy_o & ~halted_o.
REQ-020 States SHALL be IDLE, DIV, HALT: IDLE->DIV on accepted DIV with src_i!=0; DIV->IDLE after WORD iterations; IDLE->HALT on accepted HALT; HALT exits only by reset.
REQ-021 Results: ADD dest+src; SUB dest-src; AND/OR/XOR bitwise; SLT 1 if signed dest<src else 0; DIV unsigned dest/src, quotient only; all modulo 2^WORD.
REQ-022 Single-cycle ops and DIV by zero SHALL produce wb_o, rd_num_o, rd_data_o, status_o registered on the acceptance edge (latency 1).
REQ-023 DIV with src!=0 SHALL be restoring, one quotient bit per cycle, operands latched at acceptance; result registered WORD edges after acceptance edge; busy_o high from acceptance edge until that edge.
REQ-024 ready_o SHALL rise in the same cycle wb_o is asserted for a DIV result, allowing back-to-back acceptance.
REQ-025 DIV by zero SHALL give rd_data_o all ones and V=1.
REQ-026 wb_o SHALL equal wb_i captured at acceptance; rd_num_o/rd_data_o SHALL update whenever a result completes regardless of wb_i.
REQ-027 wb_o SHALL be high exactly one cycle per completed non-HALT operation with wb_i=1, else low.
REQ-028 Flags: Z=(result==0); N=result[WORD-1]; C=carry out for ADD, borrow for SUB, else 0; V=signed overflow for ADD/SUB, divide-by-zero for DIV, else 0.
REQ-029 status_o SHALL update only when a non-HALT result completes and hold otherwise.
REQ-030 HALT SHALL produce no writeback; halted_o set on acceptance edge and held.

Reset
REQ-031 Reset SHALL force state IDLE, wb_o=0, rd_num_o=0, rd_data_o=0, status_o=0, busy_o=0, halted_o=0, ready_o=1.
REQ-032 Reset asserted during DIV or HALT SHALL abort immediately with no partial writeback after release.

Verification
REQ-033 ADD dest=0x7FFFFFFF src=1 rd=3 wb=1 -> next cycle wb_o=1, rd_num_o=3, rd_data_o=0x80000000, status {Z0,C0,N1,V1}.
REQ-034 SUB dest=5 src=5 -> rd_data_o=0, Z=1,C=0; SLT dest=0xFFFFFFFF src=1 -> rd_data_o=1.
REQ-035 DIV dest=100 src=7 -> ready_o low 32 cycles, wb_o with rd_data_o=14 at 32nd edge; ADD presented meanwhile accepted only when ready_o=1.
REQ-036 DIV src=0 -> 1-cycle result 0xFFFFFFFF, V=1, busy_o never high.
REQ-037 DIV started, rst low at iteration 10 -> all outputs reset values, no wb_o after release.
REQ-038 HALT accepted -> halted_o=1, ready_o=0, no wb_o; further v_i ignored until reset.
